// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//   Memory-access pipeline stage between the ex/mem register and writeback.
//   Aligned loads and stores are issued to the data memory over a req/ack
//   handshake. Upstream is stalled while a request is outstanding.
//   Misaligned accesses are dropped and reported with a one-cycle pulse.
//   The mem/wb outputs are registered. Load words are returned raw; lane
//   extraction and sign extension are done in writeback.
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_ex_mem_*              instruction and sideband from the ex/mem register
//   o_stall                 hold ex/mem and all upstream stages
//   o_dmem_req/we/addr/...  data-memory request (word address, lane data,
//                           byte strobes)
//   i_dmem_ack/rdata        request completion and raw read word
//   o_misalign(_addr)       misaligned-access pulse and faulting address
//   o_mem_wb_*              registered mem/wb pipeline outputs
// ---------------------------------------------------------------------------
module mem_stage (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ex_mem_valid,
    input  logic        i_ex_mem_writeback,
    input  logic        i_ex_mem_mem_r,
    input  logic        i_ex_mem_mem_w,
    input  logic        i_ex_mem_mem_rdu,
    input  logic [1:0]  i_ex_mem_size,
    input  logic [31:0] i_ex_mem_alu_result,
    input  logic [31:0] i_ex_mem_store_data,
    input  logic [5:0]  i_ex_mem_rd,
    output logic        o_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_wstrb,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_misalign,
    output logic [31:0] o_misalign_addr,
    output logic        o_mem_wb_writeback,
    output logic        o_mem_wb_mem_r,
    output logic        o_mem_wb_mem_rdu,
    output logic [1:0]  o_mem_wb_mem_size,
    output logic [31:0] o_mem_wb_mem_addr,
    output logic [31:0] o_mem_wb_mem_data,
    output logic [31:0] o_mem_wb_alu_result,
    output logic [5:0]  o_mem_wb_rd
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;

    // Request registers, held constant while BUSY.
    logic        req_we_q, req_we_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [3:0]  req_wstrb_q, req_wstrb_d;

    // Instruction sideband captured at issue, replayed into mem/wb on ack.
    logic        sb_wb_q, sb_wb_d;
    logic        sb_mem_r_q, sb_mem_r_d;
    logic        sb_rdu_q, sb_rdu_d;
    logic [1:0]  sb_size_q, sb_size_d;
    logic [31:0] sb_addr_q, sb_addr_d;
    logic [5:0]  sb_rd_q, sb_rd_d;

    logic        mis_q, mis_d;
    logic [31:0] mis_addr_q, mis_addr_d;

    logic        wb_wb_q, wb_wb_d;
    logic        wb_mem_r_q, wb_mem_r_d;
    logic        wb_rdu_q, wb_rdu_d;
    logic [1:0]  wb_size_q, wb_size_d;
    logic [31:0] wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [31:0] wb_alu_q, wb_alu_d;
    logic [5:0]  wb_rd_q, wb_rd_d;

    logic        mem_op;
    logic        misaligned;
    logic [1:0]  off;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;

    assign mem_op = i_ex_mem_valid & (i_ex_mem_mem_r | i_ex_mem_mem_w);
    assign off    = i_ex_mem_alu_result[1:0];

    // Size 2'b11 is treated as a word access throughout.
    always_comb begin
        misaligned = 1'b0;
        unique case (i_ex_mem_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = off[0];
            default: misaligned = (off != 2'b00);
        endcase
    end

    // Store data is replicated across all lanes; strobes select the bytes.
    always_comb begin
        lane_wdata = '0;
        lane_wstrb = '0;
        if (i_ex_mem_mem_w) begin
            unique case (i_ex_mem_size)
                2'b00: begin
                    lane_wdata = {4{i_ex_mem_store_data[7:0]}};
                    lane_wstrb = 4'b0001 << off;
                end
                2'b01: begin
                    lane_wdata = {2{i_ex_mem_store_data[15:0]}};
                    lane_wstrb = 4'b0011 << off;
                end
                default: begin
                    lane_wdata = i_ex_mem_store_data;
                    lane_wstrb = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        sb_wb_d     = sb_wb_q;
        sb_mem_r_d  = sb_mem_r_q;
        sb_rdu_d    = sb_rdu_q;
        sb_size_d   = sb_size_q;
        sb_addr_d   = sb_addr_q;
        sb_rd_d     = sb_rd_q;
        mis_d       = 1'b0;
        mis_addr_d  = mis_addr_q;
        wb_wb_d     = 1'b0;
        wb_mem_r_d  = wb_mem_r_q;
        wb_rdu_d    = wb_rdu_q;
        wb_size_d   = wb_size_q;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        wb_alu_d    = wb_alu_q;
        wb_rd_d     = wb_rd_q;

        if (state_q == IDLE) begin
            if (!mem_op) begin
                wb_wb_d    = i_ex_mem_valid & i_ex_mem_writeback;
                wb_mem_r_d = i_ex_mem_mem_r;
                wb_rdu_d   = i_ex_mem_mem_rdu;
                wb_size_d  = i_ex_mem_size;
                wb_addr_d  = i_ex_mem_alu_result;
                wb_data_d  = '0;
                wb_alu_d   = i_ex_mem_alu_result;
                wb_rd_d    = i_ex_mem_rd;
            end else if (misaligned) begin
                // Instruction is consumed here; only the fault pulse remains.
                mis_d      = 1'b1;
                mis_addr_d = i_ex_mem_alu_result;
            end else begin
                req_we_d    = i_ex_mem_mem_w;
                req_addr_d  = {i_ex_mem_alu_result[31:2], 2'b00};
                req_wdata_d = lane_wdata;
                req_wstrb_d = lane_wstrb;
                sb_wb_d     = i_ex_mem_writeback;
                sb_mem_r_d  = i_ex_mem_mem_r;
                sb_rdu_d    = i_ex_mem_mem_rdu;
                sb_size_d   = i_ex_mem_size;
                sb_addr_d   = i_ex_mem_alu_result;
                sb_rd_d     = i_ex_mem_rd;
                state_d     = BUSY;
            end
        end else if (i_dmem_ack) begin
            wb_wb_d    = sb_wb_q;
            wb_mem_r_d = sb_mem_r_q;
            wb_rdu_d   = sb_rdu_q;
            wb_size_d  = sb_size_q;
            wb_addr_d  = sb_addr_q;
            wb_data_d  = sb_mem_r_q ? i_dmem_rdata : '0;
            wb_alu_d   = sb_addr_q;
            wb_rd_d    = sb_rd_q;
            state_d    = IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            sb_wb_q     <= 1'b0;
            sb_mem_r_q  <= 1'b0;
            sb_rdu_q    <= 1'b0;
            sb_size_q   <= '0;
            sb_addr_q   <= '0;
            sb_rd_q     <= '0;
            mis_q       <= 1'b0;
            mis_addr_q  <= '0;
            wb_wb_q     <= 1'b0;
            wb_mem_r_q  <= 1'b0;
            wb_rdu_q    <= 1'b0;
            wb_size_q   <= '0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            wb_alu_q    <= '0;
            wb_rd_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
            sb_wb_q     <= sb_wb_d;
            sb_mem_r_q  <= sb_mem_r_d;
            sb_rdu_q    <= sb_rdu_d;
            sb_size_q   <= sb_size_d;
            sb_addr_q   <= sb_addr_d;
            sb_rd_q     <= sb_rd_d;
            mis_q       <= mis_d;
            mis_addr_q  <= mis_addr_d;
            wb_wb_q     <= wb_wb_d;
            wb_mem_r_q  <= wb_mem_r_d;
            wb_rdu_q    <= wb_rdu_d;
            wb_size_q   <= wb_size_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            wb_alu_q    <= wb_alu_d;
            wb_rd_q     <= wb_rd_d;
        end
    end

    // Request and stall follow the state register directly, so an async
    // reset drops them without waiting for a clock.
    assign o_stall             = (state_q == BUSY);
    assign o_dmem_req          = (state_q == BUSY);
    assign o_dmem_we           = req_we_q;
    assign o_dmem_addr         = req_addr_q;
    assign o_dmem_wdata        = req_wdata_q;
    assign o_dmem_wstrb        = req_wstrb_q;
    assign o_misalign          = mis_q;
    assign o_misalign_addr     = mis_addr_q;
    assign o_mem_wb_writeback  = wb_wb_q;
    assign o_mem_wb_mem_r      = wb_mem_r_q;
    assign o_mem_wb_mem_rdu    = wb_rdu_q;
    assign o_mem_wb_mem_size   = wb_size_q;
    assign o_mem_wb_mem_addr   = wb_addr_q;
    assign o_mem_wb_mem_data   = wb_data_q;
    assign o_mem_wb_alu_result = wb_alu_q;
    assign o_mem_wb_rd         = wb_rd_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_ex_mem_valid, i_ex_mem_writeback, i_ex_mem_mem_r, i_ex_mem_mem_w;
    logic        i_ex_mem_mem_rdu;
    logic [1:0]  i_ex_mem_size;
    logic [31:0] i_ex_mem_alu_result, i_ex_mem_store_data;
    logic [5:0]  i_ex_mem_rd;
    logic        o_stall, o_dmem_req, o_dmem_we;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic [3:0]  o_dmem_wstrb;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic        o_misalign;
    logic [31:0] o_misalign_addr;
    logic        o_mem_wb_writeback, o_mem_wb_mem_r, o_mem_wb_mem_rdu;
    logic [1:0]  o_mem_wb_mem_size;
    logic [31:0] o_mem_wb_mem_addr, o_mem_wb_mem_data, o_mem_wb_alu_result;
    logic [5:0]  o_mem_wb_rd;

    int total = 0;
    int bad   = 0;

    mem_stage dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_ex_mem_valid(i_ex_mem_valid), .i_ex_mem_writeback(i_ex_mem_writeback),
        .i_ex_mem_mem_r(i_ex_mem_mem_r), .i_ex_mem_mem_w(i_ex_mem_mem_w),
        .i_ex_mem_mem_rdu(i_ex_mem_mem_rdu), .i_ex_mem_size(i_ex_mem_size),
        .i_ex_mem_alu_result(i_ex_mem_alu_result), .i_ex_mem_store_data(i_ex_mem_store_data),
        .i_ex_mem_rd(i_ex_mem_rd), .o_stall(o_stall), .o_dmem_req(o_dmem_req),
        .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
        .o_dmem_wstrb(o_dmem_wstrb), .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
        .o_misalign(o_misalign), .o_misalign_addr(o_misalign_addr),
        .o_mem_wb_writeback(o_mem_wb_writeback), .o_mem_wb_mem_r(o_mem_wb_mem_r),
        .o_mem_wb_mem_rdu(o_mem_wb_mem_rdu), .o_mem_wb_mem_size(o_mem_wb_mem_size),
        .o_mem_wb_mem_addr(o_mem_wb_mem_addr), .o_mem_wb_mem_data(o_mem_wb_mem_data),
        .o_mem_wb_alu_result(o_mem_wb_alu_result), .o_mem_wb_rd(o_mem_wb_rd)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic wb, input logic mr, input logic mw,
                         input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                         input logic [5:0] rd);
        i_ex_mem_valid      = v;
        i_ex_mem_writeback  = wb;
        i_ex_mem_mem_r      = mr;
        i_ex_mem_mem_w      = mw;
        i_ex_mem_mem_rdu    = 1'b0;
        i_ex_mem_size       = sz;
        i_ex_mem_alu_result = a;
        i_ex_mem_store_data = d;
        i_ex_mem_rd         = rd;
    endtask

    // Reference rules expressed arithmetically from access size.
    function automatic int unsigned nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit ref_misaligned(input logic [1:0] s, input logic [31:0] a);
        return (a % nbytes(s)) != 0;
    endfunction

    function automatic logic [3:0] ref_wstrb(input logic [1:0] s, input logic [31:0] a);
        int unsigned m;
        m = ((1 << nbytes(s)) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] s, input logic [31:0] d);
        if (nbytes(s) == 1) return {24'h0, d[7:0]} * 32'h0101_0101;
        if (nbytes(s) == 2) return {16'h0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    typedef struct {
        logic        mr, mw;
        logic [1:0]  size;
        logic [31:0] addr, data;
        logic [5:0]  rd;
        logic        exp_mis;
        logic [31:0] exp_addr, exp_wdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] rdata;
    } vec_t;

    vec_t vt[12];

    // Random-phase reference state (transaction level).
    bit          m_busy;
    logic        p_wb, p_mr, p_mw, p_rdu;
    logic [1:0]  p_size;
    logic [31:0] p_addr, p_data;
    logic [5:0]  p_rd;
    logic        e_wb, e_mr, e_mis;
    logic [31:0] e_data, e_alu, e_mis_addr;
    logic [5:0]  e_rd;

    initial begin
        vt[0]  = '{1'b1, 1'b0, 2'b10, 32'h100, 32'h0,         6'd1,  1'b0, 32'h100, 32'h0,         4'h0, 32'hDEADBEEF};
        vt[1]  = '{1'b0, 1'b1, 2'b00, 32'h203, 32'h0000_00AB, 6'd2,  1'b0, 32'h200, 32'hABABABAB, 4'h8, 32'h0};
        vt[2]  = '{1'b0, 1'b1, 2'b01, 32'h202, 32'h0000_BEEF, 6'd3,  1'b0, 32'h200, 32'hBEEFBEEF, 4'hC, 32'h0};
        vt[3]  = '{1'b0, 1'b1, 2'b10, 32'h040, 32'h1234_5678, 6'd4,  1'b0, 32'h040, 32'h12345678, 4'hF, 32'h0};
        vt[4]  = '{1'b0, 1'b1, 2'b00, 32'h201, 32'h1234_565A, 6'd5,  1'b0, 32'h200, 32'h5A5A5A5A, 4'h2, 32'h0};
        vt[5]  = '{1'b0, 1'b1, 2'b01, 32'h200, 32'hFFFF_1357, 6'd6,  1'b0, 32'h200, 32'h13571357, 4'h3, 32'h0};
        vt[6]  = '{1'b1, 1'b0, 2'b00, 32'h003, 32'h0,         6'd7,  1'b0, 32'h000, 32'h0,         4'h0, 32'h11223344};
        vt[7]  = '{1'b1, 1'b0, 2'b10, 32'h102, 32'h0,         6'd8,  1'b1, 32'h0,   32'h0,         4'h0, 32'h0};
        vt[8]  = '{1'b0, 1'b1, 2'b01, 32'h031, 32'h0000_7777, 6'd9,  1'b1, 32'h0,   32'h0,         4'h0, 32'h0};
        vt[9]  = '{1'b0, 1'b1, 2'b11, 32'h044, 32'hCAFE_F00D, 6'd10, 1'b0, 32'h044, 32'hCAFEF00D, 4'hF, 32'h0};
        vt[10] = '{1'b1, 1'b0, 2'b11, 32'h046, 32'h0,         6'd11, 1'b1, 32'h0,   32'h0,         4'h0, 32'h0};
        vt[11] = '{1'b1, 1'b0, 2'b01, 32'h006, 32'h0,         6'd12, 1'b0, 32'h004, 32'h0,         4'h0, 32'hA5A55A5A};

        i_rst_n = 1'b0;
        drive(0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 6'd0);
        i_dmem_ack = 1'b0;
        i_dmem_rdata = 32'h0;
        #1;
        chk("rst_req", o_dmem_req, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_wb", o_mem_wb_writeback, 0);
        chk("rst_mis", o_misalign, 0);
        chk("rst_alu", o_mem_wb_alu_result, 0);
        chk("rst_addr", o_dmem_addr, 0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        // ALU op passes through in one cycle with no stall.
        @(negedge i_clk);
        drive(1, 1, 0, 0, 2'b10, 32'h1234, 32'h0, 6'd5);
        chk("alu_stall_pre", o_stall, 0);
        @(posedge i_clk); #1;
        chk("alu_wb", o_mem_wb_writeback, 1);
        chk("alu_res", o_mem_wb_alu_result, 32'h1234);
        chk("alu_rd", o_mem_wb_rd, 5);
        chk("alu_data", o_mem_wb_mem_data, 0);
        chk("alu_stall", o_stall, 0);

        // Table: single accesses, zero-wait ack for aligned ones.
        for (int k = 0; k < 12; k++) begin
            @(negedge i_clk);
            drive(1, vt[k].mr, vt[k].mr, vt[k].mw, vt[k].size, vt[k].addr, vt[k].data, vt[k].rd);
            i_dmem_ack = 1'b0;
            @(posedge i_clk); #1;
            if (vt[k].exp_mis) begin
                chk("tbl_mis", o_misalign, 1);
                chk("tbl_mis_addr", o_misalign_addr, vt[k].addr);
                chk("tbl_mis_req", o_dmem_req, 0);
                chk("tbl_mis_wb", o_mem_wb_writeback, 0);
                @(negedge i_clk);
                i_ex_mem_valid = 1'b0;
                @(posedge i_clk); #1;
                chk("tbl_mis_once", o_misalign, 0);
                chk("tbl_mis_noreq", o_dmem_req, 0);
            end else begin
                chk("tbl_req", o_dmem_req, 1);
                chk("tbl_stall", o_stall, 1);
                chk("tbl_addr", o_dmem_addr, vt[k].exp_addr);
                chk("tbl_we", o_dmem_we, vt[k].mw);
                chk("tbl_wstrb", o_dmem_wstrb, vt[k].exp_wstrb);
                if (vt[k].mw) chk("tbl_wdata", o_dmem_wdata, vt[k].exp_wdata);
                chk("tbl_wb_bubble", o_mem_wb_writeback, 0);
                @(negedge i_clk);
                i_dmem_ack = 1'b1;
                i_dmem_rdata = vt[k].rdata;
                @(posedge i_clk); #1;
                chk("tbl_done_req", o_dmem_req, 0);
                chk("tbl_done_wb", o_mem_wb_writeback, vt[k].mr);
                chk("tbl_done_data", o_mem_wb_mem_data, vt[k].mr ? vt[k].rdata : 32'h0);
                chk("tbl_done_maddr", o_mem_wb_mem_addr, vt[k].addr);
                chk("tbl_done_rd", o_mem_wb_rd, vt[k].rd);
                @(negedge i_clk);
                i_dmem_ack = 1'b0;
                i_ex_mem_valid = 1'b0;
            end
        end

        // Word load with three BUSY cycles, ack in the third.
        @(negedge i_clk);
        drive(1, 1, 1, 0, 2'b10, 32'h100, 32'h0, 6'd9);
        begin
            int stall_cnt;
            stall_cnt = 0;
            @(posedge i_clk); #1;
            for (int c = 0; c < 3; c++) begin
                if (o_stall) stall_cnt++;
                chk("wl_addr", o_dmem_addr, 32'h100);
                @(negedge i_clk);
                i_dmem_ack = (c == 2);
                i_dmem_rdata = 32'hDEADBEEF;
                @(posedge i_clk); #1;
            end
            chk("wl_stall_cycles", stall_cnt, 3);
        end
        chk("wl_stall_end", o_stall, 0);
        chk("wl_data", o_mem_wb_mem_data, 32'hDEADBEEF);
        chk("wl_mem_r", o_mem_wb_mem_r, 1);
        chk("wl_wb", o_mem_wb_writeback, 1);
        @(negedge i_clk);
        i_dmem_ack = 1'b0;
        i_ex_mem_valid = 1'b0;

        // Back-to-back zero-wait loads at 0x10 and 0x14.
        @(negedge i_clk);
        drive(1, 1, 1, 0, 2'b10, 32'h10, 32'h0, 6'd1);
        @(posedge i_clk); #1;
        chk("b2b_req1", o_dmem_req, 1);
        chk("b2b_addr1", o_dmem_addr, 32'h10);
        @(negedge i_clk);
        i_dmem_ack = 1'b1;
        i_dmem_rdata = 32'h1111_0010;
        @(posedge i_clk); #1;
        chk("b2b_gap", o_dmem_req, 0);
        chk("b2b_data1", o_mem_wb_mem_data, 32'h1111_0010);
        @(negedge i_clk);
        i_dmem_ack = 1'b0;
        drive(1, 1, 1, 0, 2'b10, 32'h14, 32'h0, 6'd2);
        @(posedge i_clk); #1;
        chk("b2b_req2", o_dmem_req, 1);
        chk("b2b_addr2", o_dmem_addr, 32'h14);
        @(negedge i_clk);
        i_ex_mem_valid = 1'b0;
        i_dmem_ack = 1'b1;
        i_dmem_rdata = 32'h2222_0014;
        @(posedge i_clk); #1;
        chk("b2b_one_busy", o_dmem_req, 0);
        chk("b2b_data2", o_mem_wb_mem_data, 32'h2222_0014);
        chk("b2b_rd2", o_mem_wb_rd, 2);
        @(negedge i_clk);
        i_dmem_ack = 1'b0;

        // Asynchronous reset while BUSY, then a stale ack.
        @(negedge i_clk);
        drive(1, 1, 1, 0, 2'b10, 32'h80, 32'h0, 6'd3);
        @(posedge i_clk); #1;
        chk("rb_req", o_dmem_req, 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("rb_req_async", o_dmem_req, 0);
        chk("rb_stall_async", o_stall, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ex_mem_valid = 1'b0;
        i_dmem_ack = 1'b1;
        i_dmem_rdata = 32'h5555_5555;
        @(posedge i_clk); #1;
        chk("rb_stale_req", o_dmem_req, 0);
        chk("rb_stale_wb", o_mem_wb_writeback, 0);
        chk("rb_stale_data", o_mem_wb_mem_data, 0);
        @(negedge i_clk);
        i_dmem_ack = 1'b0;

        // Random stimulus against a transaction-level reference.
        m_busy = 0;
        for (int n = 0; n < 3000; n++) begin
            int unsigned kind;
            @(negedge i_clk);
            kind = $urandom_range(0, 2);
            i_ex_mem_valid      = ($urandom_range(0, 3) != 0);
            i_ex_mem_writeback  = $urandom_range(0, 1);
            i_ex_mem_mem_r      = (kind == 1);
            i_ex_mem_mem_w      = (kind == 2);
            i_ex_mem_mem_rdu    = $urandom_range(0, 1);
            i_ex_mem_size       = 2'($urandom_range(0, 3));
            i_ex_mem_alu_result = $urandom & 32'h0000_0FFF;
            i_ex_mem_store_data = $urandom;
            i_ex_mem_rd         = 6'($urandom_range(0, 63));
            i_dmem_ack          = ($urandom_range(0, 2) == 0);
            i_dmem_rdata        = $urandom;
            @(posedge i_clk);
            e_mis = 0;
            if (!m_busy) begin
                if (i_ex_mem_valid && (i_ex_mem_mem_r || i_ex_mem_mem_w)) begin
                    e_wb = 0;
                    if (ref_misaligned(i_ex_mem_size, i_ex_mem_alu_result)) begin
                        e_mis = 1;
                        e_mis_addr = i_ex_mem_alu_result;
                    end else begin
                        m_busy = 1;
                        p_wb = i_ex_mem_writeback; p_mr = i_ex_mem_mem_r;
                        p_mw = i_ex_mem_mem_w;     p_rdu = i_ex_mem_mem_rdu;
                        p_size = i_ex_mem_size;    p_addr = i_ex_mem_alu_result;
                        p_data = i_ex_mem_store_data; p_rd = i_ex_mem_rd;
                    end
                end else begin
                    e_wb = i_ex_mem_valid & i_ex_mem_writeback;
                    e_mr = i_ex_mem_mem_r;
                    e_data = 0;
                    e_alu = i_ex_mem_alu_result;
                    e_rd = i_ex_mem_rd;
                end
            end else if (i_dmem_ack) begin
                m_busy = 0;
                e_wb = p_wb;
                e_mr = p_mr;
                e_data = p_mr ? i_dmem_rdata : 32'h0;
                e_alu = p_addr;
                e_rd = p_rd;
            end else begin
                e_wb = 0;
            end
            #1;
            chk("rnd_req", o_dmem_req, m_busy);
            chk("rnd_stall", o_stall, m_busy);
            chk("rnd_mis", o_misalign, e_mis);
            if (e_mis) chk("rnd_mis_addr", o_misalign_addr, e_mis_addr);
            if (m_busy) begin
                chk("rnd_addr", o_dmem_addr, p_addr & 32'hFFFF_FFFC);
                chk("rnd_we", o_dmem_we, p_mw);
                chk("rnd_wstrb", o_dmem_wstrb, p_mw ? ref_wstrb(p_size, p_addr) : 4'h0);
                if (p_mw) chk("rnd_wdata", o_dmem_wdata, ref_wdata(p_size, p_data));
            end
            chk("rnd_wb", o_mem_wb_writeback, e_wb);
            if (e_wb) begin
                chk("rnd_wb_mr", o_mem_wb_mem_r, e_mr);
                chk("rnd_wb_data", o_mem_wb_mem_data, e_data);
                chk("rnd_wb_alu", o_mem_wb_alu_result, e_alu);
                chk("rnd_wb_maddr", o_mem_wb_mem_addr, e_alu);
                chk("rnd_wb_rd", o_mem_wb_rd, e_rd);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between the ex/mem pipeline register and the writeback stage.
- Performs aligned load/store requests to the data memory over a req/ack handshake and stalls upstream while a request is outstanding.
- Registers the mem/wb pipeline outputs that writeback consumes.
- Returns raw 32-bit load words; byte/half-word lane extraction and sign extension belong to writeback.

Parameters:
- None (widths fixed: 32-bit data and address, 6-bit register number).

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_ex_mem_valid  in  1  ex/mem holds a valid instruction
i_ex_mem_writeback  in  1  instruction writes rd
i_ex_mem_mem_r  in  1  load
i_ex_mem_mem_w  in  1  store
i_ex_mem_mem_rdu  in  1  unsigned load
i_ex_mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
i_ex_mem_alu_result  in  32  ALU result; effective address for loads/stores
i_ex_mem_store_data  in  32  store source, data in low bits
i_ex_mem_rd  in  6  destination register
o_stall  out  1  hold ex/mem and all upstream stages
o_dmem_req  out  1  memory request valid
o_dmem_we  out  1  1 = write
o_dmem_addr  out  32  word address, bits [1:0] forced to 0
o_dmem_wdata  out  32  lane-replicated store data
o_dmem_wstrb  out  4  byte enables (0 on reads)
i_dmem_ack  in  1  request completed this cycle; read data valid
i_dmem_rdata  in  32  raw read word
o_misalign  out  1  one-cycle pulse: misaligned access dropped
o_misalign_addr  out  32  faulting address
o_mem_wb_writeback, o_mem_wb_mem_r, o_mem_wb_mem_rdu  out  1 each  to writeback
o_mem_wb_mem_size  out  2  to writeback
o_mem_wb_mem_addr, o_mem_wb_mem_data, o_mem_wb_alu_result  out  32 each  to writeback
o_mem_wb_rd  out  6  to writeback

Behaviour:
- Reset values: all outputs 0; state IDLE. Reset asserted mid-request drops the request; o_dmem_req falls asynchronously.
- Mem op = i_ex_mem_valid & (mem_r | mem_w).
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- FSM states: IDLE, BUSY.
- IDLE, no mem op:
  - Next edge loads mem_wb from inputs; writeback = valid & i_ex_mem_writeback; mem_data = 0.
- IDLE, misaligned mem op:
  - No request.
  - Next edge: o_misalign=1, o_misalign_addr=address, mem_wb writeback=0.
  - Instruction is consumed; state stays IDLE.
- IDLE, aligned mem op:
  - Next edge latches request registers and instruction sideband.
  - mem_wb writeback=0 (bubble). State -> BUSY.
- BUSY outputs:
  - o_dmem_req=1; o_stall=1.
  - Request outputs are held constant until ack.
- BUSY, no ack: stay; mem_wb continues to present a bubble.
- BUSY with i_dmem_ack:
  - Next edge loads mem_wb from latched sideband, with mem_data = i_dmem_rdata for loads and 0 for stores.
  - mem_wb writeback = latched writeback. State -> IDLE.
  - o_stall remains 1 during the ack cycle. The next instruction is consumed only in IDLE.
- Ack with zero wait (first BUSY cycle) is legal. Ack while IDLE is ignored.
- o_stall is 0 in IDLE. IDLE sustains one instruction per cycle.
- Load latency: an instruction consumed at edge N produces a request from N; ack in cycle M; mem_wb valid after edge M+1.
- Store lanes, off = addr[1:0]:
  - byte: wdata = {4{data[7:0]}}, wstrb = 0001 << off.
  - half: wdata = {2{data[15:0]}}, wstrb = 0011 << off.
  - word: wdata = data, wstrb = 1111.
- Reads: we=0, wstrb=0000.
- o_mem_wb_mem_addr carries the full unmodified byte address so writeback can select lanes.
- o_misalign is high for exactly one cycle per faulting instruction.

Test Plan:
- ALU op: valid=1, writeback=1, alu_result=0x1234, rd=5 -> one cycle later mem_wb writeback=1, alu_result=0x1234, rd=5; o_stall never asserted.
- Word load at 0x100, ack after 3 BUSY cycles with rdata 0xDEADBEEF:
  - o_dmem_addr=0x100, we=0, wstrb=0.
  - o_stall high for 3 cycles.
  - mem_wb mem_data=0xDEADBEEF, mem_r=1, writeback=1 after the ack edge.
- Byte store: data 0xAB at 0x203 -> wdata=0xABABABAB, wstrb=1000, addr=0x200. Half store: data 0xBEEF at 0x202 -> wdata=0xBEEFBEEF, wstrb=1100.
- Misaligned word load at 0x102 -> no o_dmem_req; o_misalign pulses once with addr 0x102; mem_wb writeback=0.
- Zero-wait ack with back-to-back loads at 0x10 and 0x14 -> each load spends exactly one BUSY cycle; second request issues one cycle after the first completes.
- i_rst_n low during BUSY -> o_dmem_req and o_stall go to 0 immediately; after release, state IDLE and a stale ack is ignored.
